crl_window_assembler: RTL and testbench

- Sink end of the crl pipeline. Receives the valid-qualified crl word stream that pipeline-register stages deliver, one word per valid cycle, in raster order.
- Shifts the words into a WIN-deep horizontal window and tracks the column position within each row.
- Presents each completed window to the downstream cost stage through a registered valid/ready handshake.
- Upstream has no backpressure, so windows lost to a downstream stall are flagged, not stalled.

---
 rtl/crl_window_assembler.sv | 86 ++++++++
 tb/tb_crl_window_assembler.sv | 124 ++++++++++++
 2 files changed

// File: rtl/crl_window_assembler.sv
// crl_window_assembler: shifts the crl word stream into a WIN-deep row window and hands completed windows downstream.
// Optional CRL_WINDOW_EDGE_PAD_EN: emit a zero-padded window for every word, including the row's first WIN-1 columns.
module crl_window_assembler #(
  parameter int DATA_W = 21,
  parameter int WIN    = 5,
  parameter int LINE_W = 640
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  input  logic [DATA_W-1:0]       i_crl,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [DATA_W*WIN-1:0]   o_window,
  output logic [$clog2(LINE_W)-1:0] o_col,
  output logic                    o_last,
  output logic                    o_ovf
);
  localparam int COL_W = $clog2(LINE_W);
  localparam int FILL_W = $clog2(WIN + 1);
  localparam int SR_W = (WIN - 1) * DATA_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
  localparam logic [FILL_W-1:0] WIN_F = FILL_W'(WIN);
  // Only WIN-1 older words are stored; the incoming word completes the window.
  logic [SR_W-1:0]         sr_q, sr_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [FILL_W-1:0]       fill_q, fill_d, fill_inc;
  logic [DATA_W*WIN-1:0]   win_full, win_data;
  logic                    row_end, win_new, busy, load;
  logic                    o_valid_q, o_valid_d;
  logic [DATA_W*WIN-1:0]   o_window_q, o_window_d;
  logic [COL_W-1:0]        o_col_q, o_col_d;
  logic                    o_last_q, o_last_d;
  logic                    o_ovf_q, o_ovf_d;
  always_comb begin
    win_full = {sr_q, i_crl};
    row_end = col_q == LAST_COL;
    fill_inc = (fill_q == WIN_F) ? WIN_F : fill_q + 1'b1;
    sr_d = i_valid ? win_full[SR_W-1:0] : sr_q;
    col_d = i_valid ? (row_end ? '0 : col_q + 1'b1) : col_q;
    fill_d = i_valid ? (row_end ? '0 : fill_inc) : fill_q;
`ifdef CRL_WINDOW_EDGE_PAD_EN
    win_new = i_valid;
    win_data = win_full;
    for (int k = 0; k < WIN; k++)
      win_data[k*DATA_W +: DATA_W] = (FILL_W'(k) < fill_inc) ? win_full[k*DATA_W +: DATA_W] : '0;
`else
    win_new = i_valid && (fill_inc == WIN_F);
    win_data = win_full;
`endif
    // A held, unaccepted window keeps the output; a newer one is lost and flagged.
    busy = o_valid_q && !i_ready;
    load = win_new && !busy;
    o_valid_d = load || busy;
    o_window_d = load ? win_data : o_window_q;
    o_col_d = load ? col_q : o_col_q;
    o_last_d = load ? row_end : o_last_q;
    o_ovf_d = o_ovf_q || (win_new && busy);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q <= '0;
      col_q <= '0;
      fill_q <= '0;
      o_valid_q <= 1'b0;
      o_window_q <= '0;
      o_col_q <= '0;
      o_last_q <= 1'b0;
      o_ovf_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      col_q <= col_d;
      fill_q <= fill_d;
      o_valid_q <= o_valid_d;
      o_window_q <= o_window_d;
      o_col_q <= o_col_d;
      o_last_q <= o_last_d;
      o_ovf_q <= o_ovf_d;
    end
  end
  assign o_valid = o_valid_q;
  assign o_window = o_window_q;
  assign o_col = o_col_q;
  assign o_last = o_last_q;
  assign o_ovf = o_ovf_q;
endmodule

// File: tb/tb_crl_window_assembler.sv
// tb_crl_window_assembler: table-driven directed checks of window assembly, row wrap, gaps, reset and stall overflow.
module tb_crl_window_assembler;
  localparam int DW = 21, WN = 5, LW = 8, CW = 3;
`ifdef CRL_WINDOW_EDGE_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  typedef struct {
    logic rst, valid, ready, ev, el, chk_all;
    logic [DW-1:0] crl;
    logic [DW*WN-1:0] ew;
    logic [CW-1:0] ec;
  } vec_t;
  vec_t tbl[$];
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, ready = 1'b1;
  logic [DW-1:0] crl = '0;
  logic o_valid, o_last, o_ovf;
  logic [DW*WN-1:0] o_window;
  logic [CW-1:0] o_col;
  int total = 0, bad = 0;
  crl_window_assembler #(.DATA_W(DW), .WIN(WN), .LINE_W(LW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_crl(crl), .i_ready(ready),
    .o_valid(o_valid), .o_window(o_window), .o_col(o_col), .o_last(o_last), .o_ovf(o_ovf)
  );
  always #5 clk = ~clk;
  // Slice k holds the k-th newest word of the row; slices beyond the row fill are zero.
  function automatic logic [DW*WN-1:0] win_of(input int newest, input int f);
    logic [DW*WN-1:0] w = '0;
    for (int k = 0; k < WN; k++) w[k*DW +: DW] = (k < f) ? DW'(newest - k) : '0;
    return w;
  endfunction
  task automatic chk(input string name, input logic [DW*WN-1:0] act, input logic [DW*WN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic v, input int d, input logic rd, input logic ev,
                     input logic [DW*WN-1:0] ew, input int ec, input logic el, input logic ca);
    vec_t x;
    x.rst = r; x.valid = v; x.crl = DW'(d); x.ready = rd; x.ev = ev;
    x.ew = ew; x.ec = CW'(ec); x.el = el; x.chk_all = ca;
    tbl.push_back(x);
  endtask
  task automatic add_word(input int v, input int c);
    int f = (c + 1 > WN) ? WN : c + 1;
    logic ev = PAD || (c >= WN - 1);
    add(0, 1, v, 1, ev, ev ? win_of(v, f) : '0, c, c == LW - 1, 0);
  endtask
  task automatic add_idle();
    add(0, 0, 0, 1, 0, '0, 0, 0, 0);
  endtask
  task automatic add_rst();
    add(1, 0, 0, 1, 0, '0, 0, 0, 1);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int first, fc;
    logic [DW*WN-1:0] w0;
    // two back-to-back rows 1..8, 9..16
    add_rst();
    for (int i = 0; i < 2 * LW; i++) add_word(i + 1, i % LW);
    add_idle();
    // gapped input
    add_rst();
    for (int i = 0; i < LW; i++) begin
      add_word(i + 1, i);
      add_idle();
    end
    // reset in the middle of a row
    add_rst();
    for (int i = 0; i < 3; i++) add_word(i + 1, i);
    add_rst();
    for (int i = 0; i < LW; i++) add_word(i + 1, i);
    add_idle();
    foreach (tbl[n]) begin
      rst = tbl[n].rst; valid = tbl[n].valid; crl = tbl[n].crl; ready = tbl[n].ready;
      tick();
      chk($sformatf("valid[%0d]", n), o_valid, tbl[n].ev);
      if (tbl[n].ev || tbl[n].chk_all) begin
        chk($sformatf("window[%0d]", n), o_window, tbl[n].ew);
        chk($sformatf("col[%0d]", n), o_col, tbl[n].ec);
        chk($sformatf("last[%0d]", n), o_last, tbl[n].el);
      end
      chk($sformatf("ovf[%0d]", n), o_ovf, 0);
    end
    // downstream stall from the first window onward
    first = PAD ? 1 : WN;
    fc = PAD ? 0 : WN - 1;
    w0 = PAD ? win_of(1, 1) : win_of(WN, WN);
    rst = 1; valid = 0; ready = 1;
    tick();
    rst = 0; ready = 0;
    for (int v = 1; v <= LW; v++) begin
      valid = 1; crl = DW'(v);
      tick();
      chk($sformatf("stall_valid w%0d", v), o_valid, v >= first);
      if (v >= first) begin
        chk($sformatf("stall_window w%0d", v), o_window, w0);
        chk($sformatf("stall_col w%0d", v), o_col, fc);
        chk($sformatf("stall_last w%0d", v), o_last, 0);
      end
      chk($sformatf("stall_ovf w%0d", v), o_ovf, v > first);
    end
    valid = 0; ready = 1;
    chk("release_valid_pre", o_valid, 1);
    tick();
    chk("release_valid_post", o_valid, 0);
    chk("release_ovf_sticky", o_ovf, 1);
    tick();
    chk("release_valid_idle", o_valid, 0);
    chk("release_ovf_idle", o_ovf, 1);
    rst = 1;
    tick();
    chk("reset_clears_ovf", o_ovf, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
